// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word-by-word memory-to-memory copy engine for a single-port DataMemory
module mem_copy_engine #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_buf;
    logic              r_busy;
    logic              r_done;
    logic              r_rd;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;

    logic [ADDR_W:0]   w_len_clamped;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [ADDR_W-1:0] w_src_nxt;
    logic [ADDR_W-1:0] w_dst_cur;

    assign w_len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    assign w_cnt_nxt     = r_cnt + ONE;
    // Address sums truncate to ADDR_W bits, giving the modulo wrap for free
    assign w_src_nxt     = r_src + w_cnt_nxt[ADDR_W-1:0];
    assign w_dst_cur     = r_dst + r_cnt[ADDR_W-1:0];

    // Outputs are registered one state ahead so they line up with the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src <= src_addr;
                        r_dst <= dst_addr;
                        r_len <= w_len_clamped;
                        r_cnt <= '0;
                        if (length == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_busy  <= 1'b1;
                            r_rd    <= 1'b1;
                            r_addr  <= src_addr;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_WRITE;
                    r_buf   <= ReadData;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b1;
                    r_addr  <= w_dst_cur;
                end
                S_WRITE: begin
                    r_cnt <= w_cnt_nxt;
                    r_wr  <= 1'b0;
                    r_buf <= '0;
                    if (w_cnt_nxt == r_len) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_addr  <= '0;
                    end else begin
                        r_state <= S_READ;
                        r_rd    <= 1'b1;
                        r_addr  <= w_src_nxt;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign MemRead   = r_rd;
    assign MemWrite  = r_wr;
    assign Address   = r_addr;
    assign WriteData = r_buf;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - self-checking bench for mem_copy_engine with a behavioural memory model
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  src_addr = '0;
    logic [5:0]  dst_addr = '0;
    logic [6:0]  length = '0;
    logic        busy, done, MemRead, MemWrite;
    logic [5:0]  Address;
    logic [31:0] WriteData, ReadData;

    logic [31:0] mem [64];
    logic [31:0] init_mem [64];
    logic        pre_load = 1'b0;

    int errs = 0;
    int checks = 0;

    typedef struct {
        int src;
        int dst;
        int len;
        int exp_busy;
        int exp_done;
        bit inj;
    } vec_t;
    vec_t tbl [6];

    mem_copy_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    assign ReadData = MemRead ? mem[Address] : 32'h0;

    always @(posedge clk) begin
        if (MemWrite) mem[Address] <= WriteData;
        else if (pre_load) for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_mem();
        @(negedge clk) pre_load = 1'b1;
        @(negedge clk) pre_load = 1'b0;
    endtask

    // Reference: ascending word copy on a private image, with the per-cycle schedule of 2 cycles per word
    task automatic run_copy(input int src, input int dst, input int len,
                            input int exp_busy, input int exp_done, input bit inj, input string tag);
        logic [31:0] model [64];
        logic [31:0] v = 32'h0;
        int eff, busy_n, done_n, done_c, seq_err, mem_err, a, k;
        busy_n = 0; done_n = 0; done_c = -1; seq_err = 0; mem_err = 0;
        for (int i = 0; i < 64; i++) model[i] = mem[i];
        eff = (len > 64) ? 64 : len;
        @(negedge clk);
        src_addr = 6'(src); dst_addr = 6'(dst); length = 7'(len); start = 1'b1;
        for (int c = 1; c <= 2 * eff + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                src_addr = 6'($urandom); dst_addr = 6'($urandom); length = 7'($urandom);
            end
            start = inj && (c == 1 || c == 2 * eff + 1);
            busy_n += int'(busy);
            if (done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (c <= 2 * eff && (c % 2) == 1) begin
                k = (c - 1) / 2;
                a = (src + k) % 64;
                v = model[a];
                if (!(MemRead && !MemWrite && int'(Address) == a)) seq_err++;
            end else if (c <= 2 * eff) begin
                k = c / 2 - 1;
                a = (dst + k) % 64;
                if (!(MemWrite && !MemRead && int'(Address) == a && WriteData == v)) seq_err++;
                model[a] = v;
            end else if (MemRead || MemWrite || Address != 6'd0 || WriteData != 32'h0) begin
                seq_err++;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 64; i++) if (mem[i] !== model[i]) mem_err++;
        chk({tag, "_busy_cycles"}, busy_n, exp_busy);
        chk({tag, "_done_cycle"}, done_c, exp_done);
        chk({tag, "_done_pulses"}, done_n, 1);
        chk({tag, "_bus_sequence"}, seq_err, 0);
        chk({tag, "_mem_image"}, mem_err, 0);
    endtask

    task automatic reset_abort();
        logic [31:0] snap [64];
        int extra, bad;
        extra = 0; bad = 0;
        for (int i = 0; i < 64; i++) snap[i] = mem[i];
        @(negedge clk);
        src_addr = 6'd0; dst_addr = 6'd40; length = 7'd8; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("rst_in_write_word3", MemWrite, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs_zero", {busy, done, MemRead, MemWrite, Address, WriteData}, 0);
        repeat (3) @(negedge clk) extra += int'(done) + int'(MemWrite);
        rst_n = 1'b1;
        repeat (20) @(negedge clk) extra += int'(done) + int'(busy);
        chk("rst_no_activity_after", extra, 0);
        for (int i = 0; i < 8; i++)
            if (mem[40 + i] !== (i < 3 ? snap[i] : snap[40 + i])) bad++;
        chk("rst_partial_copy", bad, 0);
        chk("rst_mem42", mem[42], snap[2]);
    endtask

    initial begin
        int len;
        tbl[0] = '{7, 7, 5, 10, 11, 1'b0};
        tbl[1] = '{3, 50, 100, 128, 129, 1'b0};
        tbl[2] = '{63, 0, 64, 128, 129, 1'b1};
        tbl[3] = '{60, 2, 1, 2, 3, 1'b1};
        tbl[4] = '{20, 10, 9, 18, 19, 1'b0};
        tbl[5] = '{40, 44, 127, 128, 129, 1'b0};

        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        init_mem[2]  = 32'h12345678;
        init_mem[3]  = 32'h87654321;
        init_mem[62] = 32'hAAAA0001;
        init_mem[63] = 32'hBBBB0002;
        init_mem[0]  = 32'hCCCC0003;
        repeat (2) @(negedge clk);
        chk("reset_state", {busy, done, MemRead, MemWrite, Address, WriteData}, 0);
        load_mem();
        rst_n = 1'b1;
        @(negedge clk);

        run_copy(2, 10, 2, 4, 5, 1'b0, "basic");
        chk("basic_mem10", mem[10], 32'h12345678);
        chk("basic_mem11", mem[11], 32'h87654321);
        chk("basic_src_kept", {mem[2], mem[3]}, {32'h12345678, 32'h87654321});

        run_copy(62, 30, 3, 6, 7, 1'b0, "wrap");
        chk("wrap_mem30", mem[30], 32'hAAAA0001);
        chk("wrap_mem31", mem[31], 32'hBBBB0002);
        chk("wrap_mem32", mem[32], 32'hCCCC0003);

        for (int i = 0; i < 64; i++) init_mem[i] = mem[i];
        for (int i = 0; i < 4; i++) init_mem[i] = 32'(i + 1);
        load_mem();
        run_copy(0, 1, 3, 6, 7, 1'b0, "smear");
        chk("smear_words", {mem[0], mem[1], mem[2], mem[3]}, {32'd1, 32'd1, 32'd1, 32'd1});

        run_copy(5, 9, 0, 0, 1, 1'b1, "len0");
        run_copy(0, 20, 8, 16, 17, 1'b1, "ignore_start");
        run_copy(11, 33, 64, 128, 129, 1'b0, "full");

        reset_abort();
        run_copy(0, 40, 8, 16, 17, 1'b0, "after_rst");

        for (int t = 0; t < 6; t++)
            run_copy(tbl[t].src, tbl[t].dst, tbl[t].len, tbl[t].exp_busy,
                     tbl[t].exp_done, tbl[t].inj, $sformatf("tbl%0d", t));

        for (int t = 0; t < 12; t++) begin
            len = int'($urandom_range(0, 70));
            run_copy(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), len,
                     2 * (len > 64 ? 64 : len), 2 * (len > 64 ? 64 : len) + 1,
                     1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
